inst_sequencer: RTL

- On-chip initiator that replaces host-driven stimulus for `fullchip`.
- Accepts a host row stream of V and N data and forwards it on `mem_in`.
- Generates the complete 27-bit `inst` word schedule: Vmem/Nmem write, N load, execute, ofifo→pmem move, pmem read/accumulate/normalise.
- Sits between the host buffer and `fullchip`; its `inst` and `mem_in` outputs connect directly to the `fullchip` ports of the same names.

---
 rtl/inst_seq_pkg.sv | 47 ++++
 rtl/inst_seq_phase_cnt.sv | 29 ++
 rtl/inst_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/inst_seq_pkg.sv
// inst_seq_pkg: shared types and constants for the instruction sequencer.
//   state_e        - sequencer state encoding
//   INST_W         - width of the fullchip instruction word
//   B_*            - bit positions / field LSBs inside the instruction word
//   phase_next()   - successor of each fixed-length state
package inst_seq_pkg;

    localparam int INST_W = 27;

    typedef enum logic [3:0] {
        IDLE, VWR, NWR, GAP, LOAD, WAIT1, EXEC, WAIT2, OFIFO, NORM, DONE
    } state_e;

    localparam int B_NORM_ADD = 23;  // [26:23]
    localparam int B_NORM_WR  = 22;
    localparam int B_NORM_RD  = 21;
    localparam int B_NORM     = 20;
    localparam int B_DIV      = 19;
    localparam int B_ACC      = 18;
    localparam int B_COL_C    = 17;
    localparam int B_OFIFO_RD = 16;
    localparam int B_VN_ADD   = 12;  // [15:12]
    localparam int B_PMEM_ADD = 8;   // [11:8]
    localparam int B_EXEC     = 7;
    localparam int B_LOAD     = 6;
    localparam int B_VMEM_RD  = 5;
    localparam int B_VMEM_WR  = 4;
    localparam int B_NMEM_RD  = 3;
    localparam int B_NMEM_WR  = 2;
    localparam int B_PMEM_RD  = 1;
    localparam int B_PMEM_WR  = 0;

    // Fixed-length states run in this order once the row streams are done.
    function automatic state_e phase_next(input state_e s);
        case (s)
            GAP:     return LOAD;
            LOAD:    return WAIT1;
            WAIT1:   return EXEC;
            EXEC:    return WAIT2;
            WAIT2:   return OFIFO;
            OFIFO:   return NORM;
            NORM:    return DONE;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/inst_seq_phase_cnt.sv
// inst_seq_phase_cnt: loadable down-counter timing the fixed-length states.
//   clk_i, reset_ni  - clock, asynchronous active-low reset
//   load_i           - load load_val_i (length-1 of the state being entered)
//   load_val_i       - value to load
//   cnt_o            - cycles remaining after the current one
//   tc_o             - terminal count: current cycle is the last of the state
module inst_seq_phase_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)          cnt_q <= '0;
        else if (load_i)        cnt_q <= load_val_i;
        else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/inst_sequencer.sv
// inst_sequencer: on-chip initiator for fullchip. Forwards the host V/N row
// stream on mem_in and generates the full 27-bit inst schedule
// (V/N mem write, N load, execute, ofifo->pmem, pmem acc/normalise).
//   clk, reset_n    - clock, asynchronous active-low reset
//   start           - begin a run (only sampled in IDLE)
//   recon           - value driven on col_c during NORM
//   in_data/in_valid/in_ready - host row stream handshake
//   mem_in, inst    - registered outputs to fullchip
//   busy, done      - not-IDLE flag, one-cycle end-of-run pulse
// Optional (macro INST_SEQ_PERF_CNT_EN): cyc_cnt counts busy cycles,
// stall_cnt counts stream cycles without in_valid; both saturate.
module inst_sequencer
    import inst_seq_pkg::*;
#(
    parameter int total_cycle = 8,
    parameter int col         = 8,
    parameter int pr          = 8,
    parameter int bw          = 4,
    parameter int WAIT_CYC    = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 recon,
    input  logic [pr*bw*2-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [pr*bw*2-1:0]   mem_in,
    output logic [INST_W-1:0]    inst,
    output logic                 busy,
    output logic                 done
`ifdef INST_SEQ_PERF_CNT_EN
   ,output logic [15:0]          cyc_cnt,
    output logic [15:0]          stall_cnt
`endif
);

    // 4-bit address fields must not alias within a phase.
    if (total_cycle + 2 > 16 || col > 16 || total_cycle < 1 || col < 1 || WAIT_CYC < 1) begin : g_bad_cfg
        $error("inst_sequencer: unsupported total_cycle/col/WAIT_CYC");
    end

    state_e              state_q, state_d;
    logic [3:0]          row_q, row_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [pr*bw*2-1:0]  mem_q, mem_d;
    logic                accept;
    logic                ph_load, ph_tc;
    logic [15:0]         ph_val, ph_cnt;
    int                  n_d;
    logic [3:0]          n4, n4m1, n4m8;

    function automatic int phase_len(input state_e s);
        case (s)
            GAP:          return 2;
            LOAD:         return col + 2;
            WAIT1, WAIT2: return WAIT_CYC;
            EXEC, OFIFO:  return total_cycle;
            NORM:         return total_cycle + 8;
            DONE:         return 1;
            default:      return 0;
        endcase
    endfunction

    assign in_ready = (state_q == VWR) || (state_q == NWR);
    assign accept   = in_valid && in_ready;

    always_comb begin : next_state
        state_d = state_q;
        row_d   = row_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: if (start) state_d = VWR;
            VWR, NWR: begin
                if (accept) begin
                    mem_d = in_data;
                    if (row_q == 4'(((state_q == VWR) ? total_cycle : col) - 1)) begin
                        row_d   = '0;
                        state_d = (state_q == VWR) ? NWR : GAP;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end
            end
            default: if (ph_tc) state_d = phase_next(state_q);
        endcase
    end

    // inst is registered, so it is built from the state/phase index of the
    // coming cycle: index 0 on entry, otherwise one past the current index.
    assign ph_load = (state_d != state_q) && (phase_len(state_d) != 0);
    assign ph_val  = 16'(phase_len(state_d) - 1);
    assign n_d     = (state_d != state_q) ? 0 : phase_len(state_q) - int'(ph_cnt);
    assign n4      = 4'(n_d);
    assign n4m1    = 4'(n_d - 1);
    assign n4m8    = (n_d >= 8) ? 4'(n_d - 8) : 4'd0;

    inst_seq_phase_cnt #(.W(16)) u_phase (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .cnt_o      (ph_cnt),
        .tc_o       (ph_tc)
    );

    always_comb begin : inst_gen
        inst_d = '0;
        case (state_d)
            LOAD: begin
                inst_d[B_LOAD] = 1'b1;
                if (n_d >= 1 && n_d <= col) begin
                    inst_d[B_NMEM_RD]     = 1'b1;
                    inst_d[B_VN_ADD +: 4] = n4m1;
                end
            end
            EXEC: begin
                inst_d[B_EXEC]        = 1'b1;
                inst_d[B_VMEM_RD]     = 1'b1;
                inst_d[B_VN_ADD +: 4] = n4;
            end
            OFIFO: begin
                inst_d[B_OFIFO_RD]      = 1'b1;
                inst_d[B_PMEM_WR]       = 1'b1;
                inst_d[B_PMEM_ADD +: 4] = n4;
            end
            NORM: begin
                inst_d[B_COL_C]   = recon;
                inst_d[B_NORM_RD] = 1'b0;  // unused by this schedule
                inst_d[B_NORM]    = 1'b0;
                if (n_d <= total_cycle + 1) begin
                    inst_d[B_PMEM_RD]       = 1'b1;
                    inst_d[B_PMEM_ADD +: 4] = n4;
                end
                if (n_d >= 2 && n_d <= total_cycle + 1) inst_d[B_ACC] = 1'b1;
                if (n_d >= 2 && n_d <= total_cycle + 4) inst_d[B_DIV] = 1'b1;
                if (n_d >= 7) begin
                    inst_d[B_NORM_WR]       = 1'b1;
                    inst_d[B_NORM_ADD +: 4] = n4m8;
                end
            end
            default: ;
        endcase
        // Stream writes land one cycle after acceptance, so the final row's
        // write spills into the first cycle of the following state. While a
        // stream is stalled the address keeps showing the last written row.
        if (accept) begin
            inst_d[(state_q == VWR) ? B_VMEM_WR : B_NMEM_WR] = 1'b1;
            inst_d[B_VN_ADD +: 4] = row_q;
        end else if (in_ready) begin
            inst_d[B_VN_ADD +: 4] = inst_q[B_VN_ADD +: 4];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            inst_q  <= '0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            inst_q  <= inst_d;
            mem_q   <= mem_d;
        end
    end

    assign inst   = inst_q;
    assign mem_in = mem_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

`ifdef INST_SEQ_PERF_CNT_EN
    logic [15:0] cyc_q, stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else if (state_q == IDLE && start) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (busy && cyc_q != 16'hFFFF)                   cyc_q   <= cyc_q + 16'd1;
            if (in_ready && !in_valid && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
`endif

endmodule
